writeback_unit: RTL
===================

# writeback_unit

Final pipeline stage of the core and the only writer of the register file. Accepts ALU results and load requests from execute, waits for the data-memory response on loads, aligns and sign/zero-extends load data, and drives the register file's write port (rd/data). Also keeps a one-entry scoreboard so decode stalls on registers whose value is not yet readable.

## Interface
Parameters:
- XLEN, 32, data width
- REG_AW, 5, register address width

Ports:
- clk  in  1  core clock
- rstn_i  in  1  asynchronous active-low reset
- ex_valid_i  in  1  execute presents a result/load
- ex_ready_o  out  1  unit accepts; transfer when valid && ready
- ex_rd_i  in  REG_AW  destination register (0 = no write)
- ex_data_i  in  XLEN  ALU result (ignored for loads)
- ex_is_load_i  in  1  entry is a load
- ex_load_size_i  in  2  load_size_t: byte/half/word
- ex_load_unsigned_i  in  1  zero-extend instead of sign-extend
- ex_addr_lsb_i  in  2  load address bits [1:0]
- mem_rvalid_i  in  1  data-memory response valid (one cycle)
- mem_rdata_i  in  XLEN  response word
- rd_o  out  REG_AW  register-file write address (0 = no write)
- data_rd_o  out  XLEN  register-file write data
- dec_rs1_i, dec_rs2_i  in  REG_AW  decode source registers
- hazard_o  out  1  decode must stall
- protocol_err_o  out  1  sticky: response received with no load pending
- fwd_rs1_o, fwd_rs2_o  out  XLEN  forwarded data (WB_FORWARD_EN only)
- fwd_rs1_hit_o, fwd_rs2_hit_o  out  1  forward valid (WB_FORWARD_EN only)

## Operation
- FSM states: IDLE, WAIT_LOAD. Reset → IDLE.
- ex_ready_o = (state == IDLE), combinational.
- IDLE, non-load accepted: rd_o <= ex_rd_i, data_rd_o <= ex_data_i next cycle.
- IDLE, load accepted: capture rd, size, unsigned, lsb into pending regs; → WAIT_LOAD; rd_o <= 0.
- WAIT_LOAD, mem_rvalid_i: rd_o <= pending rd, data_rd_o <= aligned/extended mem_rdata_i; → IDLE.
- Alignment: byte = rdata[8*lsb +: 8]; half = rdata[16*lsb[1] +: 16] (lsb[0] ignored); word = rdata. Extend from bit 7/15 unless unsigned.
- Every cycle without a new write, rd_o <= 0 (write port held for exactly one cycle). data_rd_o holds its last value.
- rd = 0: load still waits for its response; writes nothing.
- mem_rvalid_i in IDLE: dropped, protocol_err_o <= 1, cleared only by reset.
- hazard_o = (WAIT_LOAD && pend_rd != 0 && (dec_rs1_i == pend_rd || dec_rs2_i == pend_rd)) OR the write-port term below. Source 0 never hazards.

## Timing
- Reset values: ex_ready_o 1, rd_o 0, data_rd_o 0, hazard_o 0, protocol_err_o 0, fwd_* 0; pending regs 0.
- ALU: accepted cycle N → rd_o/data_rd_o valid cycle N+1 → readable from register file cycle N+2.
- Load: accepted N; earliest response N+1; response at M → write at M+1, ex_ready_o high at M+1.
- Response and new ex_valid_i in same WAIT_LOAD cycle: new entry not accepted (ready low).
- Reset mid-load: pending discarded; a later stale response sets protocol_err_o.

## Configuration
- WB_FORWARD_EN defined: when rd_o != 0 and dec_rsX_i == rd_o, fwd_rsX_hit_o = 1, fwd_rsX_o = data_rd_o (combinational); no hazard for that match.
- Undefined: fwd_* ports tied 0; hazard_o additionally asserted when rd_o != 0 and either source equals rd_o (register file reads pre-write value).

## Structure
- core_pkg: load_size_t (LS_BYTE=0, LS_HALF=1, LS_WORD=2), wb_state_t, XLEN/REG_AW constants.
- Sub-module load_align: combinational select + extend (rdata, size, unsigned, lsb → XLEN).

## Test plan
- Reset then ALU entry rd=5, data=0xDEADBEEF at N → rd_o=5, data_rd_o=0xDEADBEEF only at N+1; rd_o=0 at N+2.
- Load byte signed, lsb=2, rd=7, response 0x12F45678 three cycles later → data_rd_o=0xFFFFFFF4, rd_o=7 one cycle after response; ex_ready_o low throughout wait.
- Load half unsigned lsb=2, rdata 0x8001ABCD → 0x00008001; word load rd=0 → no write, FSM returns IDLE.
- Pending load rd=3, dec_rs2_i=3 → hazard_o=1 until write cycle; dec_rs1_i=0 with pending rd=0 → hazard_o=0.
- rd_o=9 write cycle with dec_rs1_i=9: WB_FORWARD_EN → fwd_rs1_hit_o=1, hazard_o=0; without → hazard_o=1.
- mem_rvalid_i in IDLE, and reset asserted during WAIT_LOAD followed by a response → protocol_err_o=1, rd_o stays 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the core's writeback stage.
package core_pkg;

  localparam int CORE_XLEN   = 32;
  localparam int CORE_REG_AW = 5;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2
  } load_size_t;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half/word from a memory response word and extends it.
module load_align
  import core_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
) (
  input  logic [XLEN-1:0] rdata_i,
  input  load_size_t      size_i,
  input  logic            unsigned_i,
  input  logic [1:0]      lsb_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata_i[7:0];
    case (lsb_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
  end

  // Halfword loads ignore lsb[0]; misaligned halves are not split.
  assign w_half = lsb_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = rdata_i;
    case (size_i)
      LS_BYTE: data_o = {{(XLEN-8){~unsigned_i & w_byte[7]}}, w_byte};
      LS_HALF: data_o = {{(XLEN-16){~unsigned_i & w_half[15]}}, w_half};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: sole register-file writer, load completion and one-entry scoreboard.
// Build option WB_FORWARD_EN forwards the write-port value to decode instead of stalling.
module writeback_unit
  import core_pkg::*;
#(
  parameter int XLEN   = CORE_XLEN,
  parameter int REG_AW = CORE_REG_AW
) (
  input  logic              clk,
  input  logic              rstn_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [XLEN-1:0]   ex_data_i,
  input  logic              ex_is_load_i,
  input  load_size_t        ex_load_size_i,
  input  logic              ex_load_unsigned_i,
  input  logic [1:0]        ex_addr_lsb_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic [REG_AW-1:0] rd_o,
  output logic [XLEN-1:0]   data_rd_o,
  input  logic [REG_AW-1:0] dec_rs1_i,
  input  logic [REG_AW-1:0] dec_rs2_i,
  output logic              hazard_o,
  output logic              protocol_err_o,
  output logic [XLEN-1:0]   fwd_rs1_o,
  output logic [XLEN-1:0]   fwd_rs2_o,
  output logic              fwd_rs1_hit_o,
  output logic              fwd_rs2_hit_o,
  output wb_state_t         dbg_state_o
);

  // Handshake: an execute entry transfers on a rising clk edge where
  // ex_valid_i && ex_ready_o; ready depends on state only, never on valid.

  wb_state_t         r_state;
  wb_state_t         w_state_nxt;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_data;
  logic [REG_AW-1:0] r_pend_rd;
  load_size_t        r_pend_size;
  logic              r_pend_uns;
  logic [1:0]        r_pend_lsb;
  logic              r_protocol_err;
  logic [XLEN-1:0]   w_load_data;
  logic              w_accept;
  logic              w_load_done;
  logic              w_pend_hz;
  logic              w_wr_hz;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i    (mem_rdata_i),
    .size_i     (r_pend_size),
    .unsigned_i (r_pend_uns),
    .lsb_i      (r_pend_lsb),
    .data_o     (w_load_data)
  );

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) r_state <= WB_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WB_IDLE:      if (ex_valid_i && ex_is_load_i) w_state_nxt = WB_WAIT_LOAD;
      WB_WAIT_LOAD: if (mem_rvalid_i) w_state_nxt = WB_IDLE;
      default:      w_state_nxt = WB_IDLE;
    endcase
  end

  always_comb begin
    ex_ready_o = 1'b0;
    w_pend_hz  = 1'b0;
    case (r_state)
      WB_IDLE: ex_ready_o = 1'b1;
      WB_WAIT_LOAD:
        w_pend_hz = (r_pend_rd != '0) &&
                    ((dec_rs1_i == r_pend_rd) || (dec_rs2_i == r_pend_rd));
      default: ex_ready_o = 1'b0;
    endcase
  end

  assign w_accept    = ex_valid_i && ex_ready_o;
  assign w_load_done = (r_state == WB_WAIT_LOAD) && mem_rvalid_i;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rd           <= '0;
      r_data         <= '0;
      r_pend_rd      <= '0;
      r_pend_size    <= LS_BYTE;
      r_pend_uns     <= 1'b0;
      r_pend_lsb     <= 2'b00;
      r_protocol_err <= 1'b0;
    end else begin
      // The write port is a one-cycle pulse; data_rd_o keeps its last value.
      r_rd <= '0;
      if (w_load_done) begin
        r_rd   <= r_pend_rd;
        r_data <= w_load_data;
      end else if (w_accept) begin
        if (ex_is_load_i) begin
          r_pend_rd   <= ex_rd_i;
          r_pend_size <= ex_load_size_i;
          r_pend_uns  <= ex_load_unsigned_i;
          r_pend_lsb  <= ex_addr_lsb_i;
        end else begin
          r_rd   <= ex_rd_i;
          r_data <= ex_data_i;
        end
      end
      if ((r_state == WB_IDLE) && mem_rvalid_i) r_protocol_err <= 1'b1;
    end
  end

`ifdef WB_FORWARD_EN
  assign fwd_rs1_hit_o = (r_rd != '0) && (dec_rs1_i == r_rd);
  assign fwd_rs2_hit_o = (r_rd != '0) && (dec_rs2_i == r_rd);
  assign fwd_rs1_o     = fwd_rs1_hit_o ? r_data : '0;
  assign fwd_rs2_o     = fwd_rs2_hit_o ? r_data : '0;
  assign w_wr_hz       = 1'b0;
`else
  // The register file returns the pre-write value during the write cycle.
  assign fwd_rs1_hit_o = 1'b0;
  assign fwd_rs2_hit_o = 1'b0;
  assign fwd_rs1_o     = '0;
  assign fwd_rs2_o     = '0;
  assign w_wr_hz       = (r_rd != '0) && ((dec_rs1_i == r_rd) || (dec_rs2_i == r_rd));
`endif

  assign hazard_o       = w_pend_hz | w_wr_hz;
  assign rd_o           = r_rd;
  assign data_rd_o      = r_data;
  assign protocol_err_o = r_protocol_err;
  assign dbg_state_o    = r_state;

endmodule
